// File: rtl/ecd_pkg.sv
// Shared types and helper constants for the rotation-group rearrange controller.
// Module-local sizes come from the helper functions; HALF_N/MOD_MASK describe the default ring.
package ecd_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} ecd_state_e;

  localparam int unsigned DEF_POLY_POWER = 8192;

  function automatic int unsigned half_n(input int unsigned n);
    return n / 2;
  endfunction

  // Powers live modulo 2N, and 2N is a power of two, so the reduction is a mask.
  function automatic int unsigned mod_mask(input int unsigned n);
    return 2 * n - 1;
  endfunction

  localparam int unsigned HALF_N   = half_n(DEF_POLY_POWER);
  localparam int unsigned MOD_MASK = mod_mask(DEF_POLY_POWER);

endpackage

// File: rtl/ecd_pow_step.sv
// Combinational power step: p_next = p * ROTATE_BASE mod 2N.
module ecd_pow_step
  import ecd_pkg::*;
#(
  parameter int unsigned POLY_POWER  = 8192,
  parameter int unsigned ROTATE_BASE = 3,
  parameter int unsigned ADDR_WIDTH  = 12
) (
  input  logic [ADDR_WIDTH+1:0] p,
  output logic [ADDR_WIDTH+1:0] p_next
);

  localparam int unsigned PowWidth = ADDR_WIDTH + 2;
  localparam logic [PowWidth-1:0] Mask = PowWidth'(mod_mask(POLY_POWER));
  localparam logic [PowWidth-1:0] Base = PowWidth'(ROTATE_BASE);

  assign p_next = (p * Base) & Mask;

endmodule

// File: rtl/ecd_rarg_ctrl.sv
// Rearrange-pass controller: emits N/2 slot descriptors walking powers of ROTATE_BASE mod 2N.
// Optional macro ECD_RARG_STALL_CNT_EN adds a 32-bit stall_cnt output.
module ecd_rarg_ctrl
  import ecd_pkg::*;
#(
  parameter int unsigned POLY_POWER  = 8192,
  parameter int unsigned ROTATE_BASE = 3,
  parameter int unsigned ADDR_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_vld,
  output logic                  start_rdy,
  input  logic                  abort,
  output logic                  slot_vld,
  input  logic                  slot_rdy,
  output logic [ADDR_WIDTH-1:0] slot_idx,
  output logic [ADDR_WIDTH-1:0] slot_addr,
  output logic                  slot_im,
  output logic                  busy,
  output logic                  done
`ifdef ECD_RARG_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned PowWidth = ADDR_WIDTH + 2;
  localparam int unsigned HalfN    = half_n(POLY_POWER);
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(HalfN - 1);
  localparam logic [PowWidth-1:0]   HalfNP  = PowWidth'(HalfN);
  localparam logic [PowWidth-1:0]   TopAddr = PowWidth'(POLY_POWER - 1);

  ecd_state_e            state_q;
  logic [ADDR_WIDTH-1:0] k_q;
  logic [PowWidth-1:0]   p_q;
  logic [PowWidth-1:0]   p_step;
  logic [PowWidth-1:0]   t_step;
  logic [ADDR_WIDTH-1:0] addr_step;
  logic                  im_step;
  logic                  start_acc;
  logic                  slot_acc;
  logic                  slot_vld_q;
  logic [ADDR_WIDTH-1:0] slot_addr_q;
  logic                  slot_im_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  start_rdy_q;

  ecd_pow_step #(
    .POLY_POWER (POLY_POWER),
    .ROTATE_BASE(ROTATE_BASE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pow_step (
    .p     (p_q),
    .p_next(p_step)
  );

  // Descriptor for the next power; slots in the upper half map mirrored onto the conjugate half.
  always_comb begin
    t_step    = (p_step - PowWidth'(1)) >> 1;
    im_step   = t_step < HalfNP;
    addr_step = ADDR_WIDTH'(im_step ? t_step : TopAddr - t_step);
  end

  assign start_acc = start_vld & start_rdy_q;
  assign slot_acc  = slot_vld_q & slot_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      p_q         <= PowWidth'(1);
      slot_vld_q  <= 1'b0;
      slot_addr_q <= '0;
      slot_im_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_rdy_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_acc) begin
            state_q     <= StRun;
            k_q         <= '0;
            p_q         <= PowWidth'(1);
            slot_vld_q  <= 1'b1;
            slot_addr_q <= '0;
            slot_im_q   <= 1'b1;
            busy_q      <= 1'b1;
            start_rdy_q <= 1'b0;
          end
        end
        StRun: begin
          if (abort) begin
            state_q     <= StIdle;
            slot_vld_q  <= 1'b0;
            busy_q      <= 1'b0;
            start_rdy_q <= 1'b1;
          end else if (slot_acc) begin
            if (k_q == LastIdx) begin
              state_q    <= StDone;
              slot_vld_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              k_q         <= k_q + 1'b1;
              p_q         <= p_step;
              slot_addr_q <= addr_step;
              slot_im_q   <= im_step;
            end
          end
        end
        StDone: begin
          state_q     <= StIdle;
          busy_q      <= 1'b0;
          start_rdy_q <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          slot_vld_q  <= 1'b0;
          busy_q      <= 1'b0;
          start_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign start_rdy = start_rdy_q;
  assign slot_vld  = slot_vld_q;
  assign slot_idx  = k_q;
  assign slot_addr = slot_addr_q;
  assign slot_im   = slot_im_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef ECD_RARG_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (state_q == StRun && slot_vld_q && !slot_rdy && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ecd_rarg_ctrl.sv
// Self-checking bench for ecd_rarg_ctrl at N=16: directed vectors, corner sequences, random run.
module tb_ecd_rarg_ctrl;

  localparam int N  = 16;
  localparam int RB = 3;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          start_vld;
  logic          start_rdy;
  logic          abort;
  logic          slot_vld;
  logic          slot_rdy;
  logic [AW-1:0] slot_idx;
  logic [AW-1:0] slot_addr;
  logic          slot_im;
  logic          busy;
  logic          done;
`ifdef ECD_RARG_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ecd_rarg_ctrl #(
    .POLY_POWER (N),
    .ROTATE_BASE(RB),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_vld(start_vld),
    .start_rdy(start_rdy),
    .abort    (abort),
    .slot_vld (slot_vld),
    .slot_rdy (slot_rdy),
    .slot_idx (slot_idx),
    .slot_addr(slot_addr),
    .slot_im  (slot_im),
    .busy     (busy),
    .done     (done)
`ifdef ECD_RARG_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: slot k corresponds to power RB^k mod 2N.
  function automatic int ref_p(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = (p * RB) % (2 * N);
    return p;
  endfunction

  function automatic int ref_addr(input int k);
    int t = (ref_p(k) - 1) / 2;
    return (t < N / 2) ? t : N - 1 - t;
  endfunction

  function automatic int ref_im(input int k);
    return ((ref_p(k) - 1) / 2 < N / 2) ? 1 : 0;
  endfunction

  // Called at a negedge while idle; returns at the first negedge of RUN.
  task automatic start_pass();
    start_vld = 1'b1;
    @(negedge clk);
    start_vld = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  typedef struct {
    bit rdy;
    bit vld;
    int idx;
    int addr;
    bit im;
    bit dn;
  } vec_t;

  vec_t tbl[10];

  int m_mode;
  int m_k;
  int m_stall;
  int done_at;

  initial begin
    tbl[0] = '{1, 1, 0, 0, 1, 0};
    tbl[1] = '{1, 1, 1, 1, 1, 0};
    tbl[2] = '{1, 1, 2, 4, 1, 0};
    tbl[3] = '{1, 1, 3, 2, 0, 0};
    tbl[4] = '{1, 1, 4, 7, 0, 0};
    tbl[5] = '{1, 1, 5, 6, 0, 0};
    tbl[6] = '{1, 1, 6, 3, 0, 0};
    tbl[7] = '{1, 1, 7, 5, 1, 0};
    tbl[8] = '{1, 0, 0, 0, 0, 1};
    tbl[9] = '{1, 0, 0, 0, 0, 0};

    rst_n     = 1'b0;
    start_vld = 1'b0;
    abort     = 1'b0;
    slot_rdy  = 1'b0;
    #12;
    check("rst_slot_vld", 32'(slot_vld), 0);
    check("rst_slot_idx", 32'(slot_idx), 0);
    check("rst_slot_addr", 32'(slot_addr), 0);
    check("rst_slot_im", 32'(slot_im), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_start_rdy", 32'(start_rdy), 1);
`ifdef ECD_RARG_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif

    // Full-rate pass against the vector table.
    slot_rdy = 1'b1;
    start_pass();
    for (int i = 0; i < 10; i++) begin
      slot_rdy = tbl[i].rdy;
      check($sformatf("tbl%0d_vld", i), 32'(slot_vld), 32'(tbl[i].vld));
      check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].dn));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].vld | tbl[i].dn));
      if (tbl[i].vld) begin
        check($sformatf("tbl%0d_idx", i), 32'(slot_idx), 32'(tbl[i].idx));
        check($sformatf("tbl%0d_addr", i), 32'(slot_addr), 32'(tbl[i].addr));
        check($sformatf("tbl%0d_im", i), 32'(slot_im), 32'(tbl[i].im));
      end
      @(negedge clk);
    end

    // Backpressure for three cycles at k=3.
    slot_rdy = 1'b1;
    start_pass();
    done_at = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      slot_rdy = (cyc >= 4 && cyc <= 6) ? 1'b0 : 1'b1;
      if (cyc >= 4 && cyc <= 7) begin
        check("stall_vld", 32'(slot_vld), 1);
        check("stall_idx", 32'(slot_idx), 3);
        check("stall_addr", 32'(slot_addr), 2);
        check("stall_im", 32'(slot_im), 0);
      end
      if (done && done_at == 0) done_at = cyc;
      @(negedge clk);
    end
    check("stall_done_cycle", 32'(done_at), 12);
`ifdef ECD_RARG_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 3);
`endif

    // Abort coincident with the k=4 handshake.
    slot_rdy = 1'b1;
    start_pass();
    repeat (4) @(negedge clk);
    check("abort_pre_idx", 32'(slot_idx), 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_vld", 32'(slot_vld), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_start_rdy", 32'(start_rdy), 1);
    done_at = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_at = 1;
      @(negedge clk);
    end
    check("abort_no_done", 32'(done_at), 0);
    start_pass();
    check("abort_restart_vld", 32'(slot_vld), 1);
    check("abort_restart_idx", 32'(slot_idx), 0);
    check("abort_restart_addr", 32'(slot_addr), 0);
    wait_done("abort_restart_done");

    // start_vld held through a whole pass.
    slot_rdy  = 1'b1;
    start_vld = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc <= 9) begin
        check("hold_start_rdy_busy", 32'(start_rdy), 0);
        check("hold_busy", 32'(busy), 1);
      end
      if (cyc == 9) check("hold_done", 32'(done), 1);
      if (cyc == 10) check("hold_start_rdy_after", 32'(start_rdy), 1);
      @(negedge clk);
    end
    check("hold_second_vld", 32'(slot_vld), 1);
    check("hold_second_idx", 32'(slot_idx), 0);
    start_vld = 1'b0;
    wait_done("hold_second_done");

    // Reset in the middle of a pass at k=5.
    slot_rdy = 1'b1;
    start_pass();
    repeat (5) @(negedge clk);
    check("mid_rst_pre_idx", 32'(slot_idx), 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(slot_vld), 0);
    check("mid_rst_idx", 32'(slot_idx), 0);
    check("mid_rst_addr", 32'(slot_addr), 0);
    check("mid_rst_im", 32'(slot_im), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_start_rdy", 32'(start_rdy), 1);
    @(negedge clk);

    // Random traffic against the behavioural model.
    m_mode  = 0;
    m_k     = 0;
    m_stall = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      check("rnd_start_rdy", 32'(start_rdy), 32'(m_mode == 0));
      check("rnd_busy", 32'(busy), 32'(m_mode != 0));
      check("rnd_done", 32'(done), 32'(m_mode == 2));
      check("rnd_vld", 32'(slot_vld), 32'(m_mode == 1));
      if (m_mode == 1) begin
        check("rnd_idx", 32'(slot_idx), 32'(m_k));
        check("rnd_addr", 32'(slot_addr), 32'(ref_addr(m_k)));
        check("rnd_im", 32'(slot_im), 32'(ref_im(m_k)));
      end
`ifdef ECD_RARG_STALL_CNT_EN
      check("rnd_stall_cnt", stall_cnt, 32'(m_stall));
`endif
      start_vld = ($urandom_range(0, 3) == 0);
      slot_rdy  = ($urandom_range(0, 3) != 0);
      abort     = ($urandom_range(0, 49) == 0);
      case (m_mode)
        0: if (start_vld) begin
          m_mode  = 1;
          m_k     = 0;
          m_stall = 0;
        end
        1: begin
          if (!slot_rdy) m_stall++;
          if (abort) m_mode = 0;
          else if (slot_rdy) begin
            if (m_k == N / 2 - 1) m_mode = 2;
            else m_k++;
          end
        end
        default: m_mode = 0;
      endcase
      @(negedge clk);
    end
    start_vld = 1'b0;
    abort     = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecd_rarg_ctrl.md
ECD_RARG_CTRL -- requirements
Module: ecd_rarg_ctrl

Interface
REQ-001 SHALL have parameter POLY_POWER, default 8192, ring degree N (power of two, >= 16).
REQ-002 SHALL have parameter ROTATE_BASE, default 3, odd rotation-group generator.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12, equal to log2(N/2).
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_vld  in  1  request to run one rearrange pass.
REQ-007 SHALL have port start_rdy  out  1  high only in IDLE.
REQ-008 SHALL have port abort  in  1  synchronous cancel of the current pass.
REQ-009 SHALL have port slot_vld  out  1  slot descriptor valid.
REQ-010 SHALL have port slot_rdy  in  1  downstream accepts the descriptor.
REQ-011 SHALL have port slot_idx  out  ADDR_WIDTH  sequence index k.
REQ-012 SHALL have port slot_addr  out  ADDR_WIDTH  rearranged buffer address.
REQ-013 SHALL have port slot_im  out  1  1 = imaginary half, 0 = conjugate half.
REQ-014 SHALL have port busy  out  1  high in RUN and DONE.
REQ-015 SHALL have port done  out  1  one-cycle pulse at pass completion.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL move IDLE->RUN on start_vld&start_rdy, with k=0 and p=1.
REQ-018 SHALL assert slot_vld in every RUN cycle, starting the cycle after start acceptance.
REQ-019 SHALL keep all slot_* outputs registered and stable while slot_vld&!slot_rdy.
REQ-020 SHALL advance on slot_vld&slot_rdy: k<=k+1 and p<=(p*ROTATE_BASE) mod 2N, using log2(N)+1-bit wrap arithmetic.
REQ-021 SHALL derive t=(p-1)>>1; if t<N/2 then slot_addr=t and slot_im=1, else slot_addr=N-1-t and slot_im=0.
REQ-022 SHALL move RUN->DONE on acceptance of k=N/2-1, then DONE->IDLE after exactly one cycle with done=1.
REQ-023 SHALL sustain one slot per cycle while slot_rdy is held high: N/2 slots in N/2 cycles, done at cycle N/2+1 after start.
REQ-024 SHALL, on abort in any state, return to IDLE next cycle with slot_vld=0 and no done pulse; abort has priority over a simultaneous handshake.
REQ-025 SHALL ignore start_vld while busy, and SHALL ignore abort in IDLE.
REQ-026 SHALL accept a new start in the cycle immediately after done.

Reset
REQ-027 SHALL on rst_n low, including mid-pass, force IDLE, k=0, p=1, slot_vld=0, slot_idx=0, slot_addr=0, slot_im=0, busy=0, done=0 and start_rdy=1 after release.

Configuration
REQ-028 SHALL, with ECD_RARG_STALL_CNT_EN defined, add output stall_cnt (32 bits) counting RUN cycles with slot_vld&!slot_rdy, cleared on start acceptance and on reset, saturating at all-ones.
REQ-029 SHALL, without ECD_RARG_STALL_CNT_EN, omit the stall_cnt port and its logic entirely.

Structure
REQ-030 SHALL place the FSM state enum and the helper constants HALF_N and MOD_MASK in shared package ecd_pkg.
REQ-031 SHALL implement the power step p*ROTATE_BASE mod 2N in sub-module ecd_pow_step, which is purely combinational and parameterised like the parent.

Verification (N=16, ADDR_WIDTH=3, ROTATE_BASE=3)
REQ-032 SHALL check: start with slot_rdy=1 -> (addr,im) for k=0..7 equals (0,1)(1,1)(4,1)(2,0)(7,0)(6,0)(3,0)(5,1), and done pulses at cycle 9.
REQ-033 SHALL check: slot_rdy low for 3 cycles at k=3 -> slot_addr=2 and slot_im=0 held stable, done is delayed by 3 cycles, and stall_cnt=3 when the macro is enabled.
REQ-034 SHALL check: abort together with the k=4 handshake -> IDLE next cycle, no done, and the next start restarts at k=0, addr=0.
REQ-035 SHALL check: start_vld held high throughout a pass -> start_rdy=0 while busy, and a second pass begins the cycle after done.
REQ-036 SHALL check: rst_n asserted at k=5 -> all outputs are at reset values and start_rdy=1 after release.
